// File: rtl/fir_coeff_loader.sv
// Coefficient loader: accepts signed host beats and writes their magnitudes into
// a positive and a negative SRAM bank, one registered write per accepted beat.
module fir_coeff_loader (
    input  logic        iClk_12M,
    input  logic        iRst,
    input  logic        iLoadStart,
    input  logic [5:0]  iNumOfCoeff,
    input  logic        iCoeffValid,
    input  logic [15:0] iCoeffData,
    output logic        oCoeffReady,
    output logic        oCoeffiUpdateFlag,
    output logic        oCsnRam,
    output logic        oWrnRam,
    output logic [3:0]  oAddrRam_pos,
    output logic [3:0]  oAddrRam_neg,
    output logic [15:0] oWrDtRam,
    output logic [5:0]  oNumOfCoeff,
    output logic        oBusy,
    output logic        oDone,
    output logic        oErr,
    output logic [1:0]  oState
);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2, ERR = 2'd3} state_t;

    state_t      state_q;
    logic [5:0]  n_q, cnt_q, nwr_q;
    logic [3:0]  pos_cnt_q, neg_cnt_q, addr_pos_q, addr_neg_q;
    logic [15:0] dat_q;
    logic        csn_q, wrn_q, upd_q, busy_q, done_q, err_q;

    logic        accept_d, is_neg_d, overflow_d;
    logic [15:0] mag_d;

    // Handshake: a beat transfers on a rising edge where iCoeffValid && oCoeffReady.
    assign oCoeffReady = (state_q == LOAD) && (cnt_q < n_q);
    assign accept_d    = iCoeffValid && oCoeffReady;
    assign is_neg_d    = iCoeffData[15];
    assign overflow_d  = is_neg_d ? (neg_cnt_q == 4'd15) : (pos_cnt_q == 4'd15);

    // -0x8000 is not representable, so the most negative input saturates.
    always_comb begin
        mag_d = iCoeffData;
        if (is_neg_d) begin
            mag_d = (iCoeffData == 16'h8000) ? 16'h7FFF : (16'd0 - iCoeffData);
        end
    end

    always_ff @(posedge iClk_12M) begin
        if (iRst) begin
            state_q    <= IDLE;
            n_q        <= '0;
            cnt_q      <= '0;
            nwr_q      <= '0;
            pos_cnt_q  <= '0;
            neg_cnt_q  <= '0;
            addr_pos_q <= '0;
            addr_neg_q <= '0;
            dat_q      <= '0;
            csn_q      <= 1'b1;
            wrn_q      <= 1'b1;
            upd_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            csn_q  <= 1'b1;
            wrn_q  <= 1'b1;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (iLoadStart) begin
                        n_q       <= iNumOfCoeff;
                        cnt_q     <= '0;
                        nwr_q     <= '0;
                        pos_cnt_q <= '0;
                        neg_cnt_q <= '0;
                        if (iNumOfCoeff == 6'd0 || iNumOfCoeff > 6'd30) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= LOAD;
                            err_q   <= 1'b0;
                            upd_q   <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (accept_d) begin
                        cnt_q <= cnt_q + 6'd1;
                        if (overflow_d) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                            upd_q   <= 1'b0;
                            busy_q  <= 1'b0;
                        end else begin
                            csn_q <= 1'b0;
                            wrn_q <= 1'b0;
                            dat_q <= mag_d;
                            nwr_q <= nwr_q + 6'd1;
                            if (is_neg_d) begin
                                neg_cnt_q  <= neg_cnt_q + 4'd1;
                                addr_neg_q <= neg_cnt_q + 4'd1;
                            end else begin
                                pos_cnt_q  <= pos_cnt_q + 4'd1;
                                addr_pos_q <= pos_cnt_q + 4'd1;
                            end
                            if (cnt_q + 6'd1 == n_q) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    upd_q   <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign oCoeffiUpdateFlag = upd_q;
    assign oCsnRam           = csn_q;
    assign oWrnRam           = wrn_q;
    assign oAddrRam_pos      = addr_pos_q;
    assign oAddrRam_neg      = addr_neg_q;
    assign oWrDtRam          = dat_q;
    assign oNumOfCoeff       = nwr_q;
    assign oBusy             = busy_q;
    assign oDone             = done_q;
    assign oErr              = err_q;
    assign oState            = state_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader: a reference model pushes expected SRAM
// writes {addr_pos, addr_neg, data} into a queue that a write monitor drains.
module tb_fir_coeff_loader;

  logic        clk = 1'b0;
  logic        iRst, iLoadStart, iCoeffValid;
  logic [5:0]  iNumOfCoeff;
  logic [15:0] iCoeffData;
  logic        oCoeffReady, oCoeffiUpdateFlag, oCsnRam, oWrnRam;
  logic [3:0]  oAddrRam_pos, oAddrRam_neg;
  logic [15:0] oWrDtRam;
  logic [5:0]  oNumOfCoeff;
  logic        oBusy, oDone, oErr;
  logic [1:0]  oState;

  localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_DONE = 2'd2, S_ERR = 2'd3;

  fir_coeff_loader dut (
    .iClk_12M(clk), .iRst(iRst), .iLoadStart(iLoadStart), .iNumOfCoeff(iNumOfCoeff),
    .iCoeffValid(iCoeffValid), .iCoeffData(iCoeffData), .oCoeffReady(oCoeffReady),
    .oCoeffiUpdateFlag(oCoeffiUpdateFlag), .oCsnRam(oCsnRam), .oWrnRam(oWrnRam),
    .oAddrRam_pos(oAddrRam_pos), .oAddrRam_neg(oAddrRam_neg), .oWrDtRam(oWrDtRam),
    .oNumOfCoeff(oNumOfCoeff), .oBusy(oBusy), .oDone(oDone), .oErr(oErr), .oState(oState)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [23:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  logic [3:0] m_pos_cnt, m_neg_cnt, m_pos_addr, m_neg_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && oCsnRam === 1'b0) begin
      chk("write_wrn_low", {31'd0, oWrnRam}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write_csn", {31'd0, oCsnRam}, 32'd1);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        chk("write_addr_data", {8'd0, oAddrRam_pos, oAddrRam_neg, oWrDtRam}, {8'd0, e});
      end
    end
  end

  // model of one accepted beat; an overflowing beat produces no write
  task automatic model_accept(input logic [15:0] d);
    logic [15:0] mag;
    if (d[15]) begin
      mag = (d == 16'h8000) ? 16'h7FFF : (~d + 16'd1);
      if (m_neg_cnt != 4'd15) begin
        m_neg_cnt++;
        m_neg_addr = m_neg_cnt;
        exp_q.push_back({m_pos_addr, m_neg_addr, mag});
      end
    end else begin
      if (m_pos_cnt != 4'd15) begin
        m_pos_cnt++;
        m_pos_addr = m_pos_cnt;
        exp_q.push_back({m_pos_addr, m_neg_addr, d});
      end
    end
  endtask

  // driver tasks
  task automatic do_reset();
    iRst = 1'b1; iLoadStart = 1'b0; iNumOfCoeff = '0; iCoeffValid = 1'b0; iCoeffData = '0;
    repeat (3) @(posedge clk);
    #1 iRst = 1'b0;
    m_pos_cnt = '0; m_neg_cnt = '0; m_pos_addr = '0; m_neg_addr = '0;
    mon_en = 1'b1;
  endtask

  task automatic start_load(input logic [5:0] n);
    @(negedge clk);
    iLoadStart = 1'b1; iNumOfCoeff = n;
    m_pos_cnt = '0; m_neg_cnt = '0;
    @(posedge clk);
    #1 iLoadStart = 1'b0;
  endtask

  task automatic send_beat(input logic [15:0] d);
    int t;
    t = 0;
    @(negedge clk);
    iCoeffValid = 1'b1; iCoeffData = d;
    while (oCoeffReady !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("beat_ready", {31'd0, oCoeffReady}, 32'd1);
    if (oCoeffReady === 1'b1) model_accept(d);
    @(posedge clk);
    #1 iCoeffValid = 1'b0;
  endtask

  task automatic check_done(input string tag, input logic [5:0] n);
    @(negedge clk);
    chk({tag, "_done"}, {31'd0, oDone}, 32'd1);
    chk({tag, "_state_done"}, {30'd0, oState}, {30'd0, S_DONE});
    chk({tag, "_upd_done"}, {31'd0, oCoeffiUpdateFlag}, 32'd1);
    chk({tag, "_busy_done"}, {31'd0, oBusy}, 32'd0);
    chk({tag, "_num"}, {26'd0, oNumOfCoeff}, {26'd0, n});
    @(negedge clk);
    chk({tag, "_done_drop"}, {31'd0, oDone}, 32'd0);
    chk({tag, "_state_idle"}, {30'd0, oState}, {30'd0, S_IDLE});
    chk({tag, "_upd_idle"}, {31'd0, oCoeffiUpdateFlag}, 32'd0);
  endtask

  logic [15:0] stim [12];
  logic [5:0]  bad_n [2];

  initial begin
    stim = '{16'h0003, 16'hFFFA, 16'h0007, 16'hFFF5, 16'h000D, 16'hFFED,
             16'h0018, 16'hFFDB, 16'h0030, 16'hFF9A, 16'h00CE, 16'h01F4};
    bad_n = '{6'd0, 6'd31};

    // reset values
    do_reset();
    @(negedge clk);
    chk("rst_csn", {31'd0, oCsnRam}, 32'd1);
    chk("rst_wrn", {31'd0, oWrnRam}, 32'd1);
    chk("rst_flags", {27'd0, oCoeffiUpdateFlag, oCoeffReady, oBusy, oDone, oErr}, 32'd0);
    chk("rst_addr_data", {8'd0, oAddrRam_pos, oAddrRam_neg, oWrDtRam}, 32'd0);
    chk("rst_num", {26'd0, oNumOfCoeff}, 32'd0);
    chk("rst_state", {30'd0, oState}, {30'd0, S_IDLE});

    // N=12 back-to-back
    start_load(6'd12);
    @(negedge clk);
    chk("t1_state_load", {30'd0, oState}, {30'd0, S_LOAD});
    chk("t1_busy", {31'd0, oBusy}, 32'd1);
    chk("t1_upd", {31'd0, oCoeffiUpdateFlag}, 32'd1);
    for (int i = 0; i < 12; i++) send_beat(stim[i]);
    check_done("t1", 6'd12);
    chk("t1_final_addr_data", {8'd0, oAddrRam_pos, oAddrRam_neg, oWrDtRam}, {8'd0, 4'd7, 4'd5, 16'h01F4});

    // N=12 with valid toggling; a start during LOAD is ignored
    start_load(6'd12);
    @(negedge clk);
    iLoadStart = 1'b1; iNumOfCoeff = 6'd0;
    @(posedge clk);
    #1 iLoadStart = 1'b0;
    @(negedge clk);
    chk("t2_start_ignored_state", {30'd0, oState}, {30'd0, S_LOAD});
    chk("t2_start_ignored_err", {31'd0, oErr}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      send_beat(stim[i]);
      if (i < 11) begin
        @(negedge clk);
        chk("t2_upd_gap", {31'd0, oCoeffiUpdateFlag}, 32'd1);
      end
    end
    check_done("t2", 6'd12);
    chk("t2_final_addr", {24'd0, oAddrRam_pos, oAddrRam_neg}, {24'd0, 4'd7, 4'd5});

    // illegal N
    for (int k = 0; k < 2; k++) begin
      start_load(bad_n[k]);
      @(negedge clk);
      chk("t3_err", {31'd0, oErr}, 32'd1);
      chk("t3_state_err", {30'd0, oState}, {30'd0, S_ERR});
      chk("t3_ready", {31'd0, oCoeffReady}, 32'd0);
      chk("t3_upd", {31'd0, oCoeffiUpdateFlag}, 32'd0);
      @(negedge clk);
      chk("t3_state_idle", {30'd0, oState}, {30'd0, S_IDLE});
      chk("t3_err_sticky", {31'd0, oErr}, 32'd1);
      chk("t3_ready_idle", {31'd0, oCoeffReady}, 32'd0);
    end

    // positive bank overflow
    start_load(6'd20);
    for (int i = 0; i < 16; i++) send_beat(16'(i * 16 + 1));
    @(negedge clk);
    chk("t4_state_err", {30'd0, oState}, {30'd0, S_ERR});
    chk("t4_err", {31'd0, oErr}, 32'd1);
    chk("t4_addr_pos", {28'd0, oAddrRam_pos}, 32'd15);
    chk("t4_num", {26'd0, oNumOfCoeff}, 32'd15);
    repeat (4) @(negedge clk);
    chk("t4_err_sticky", {31'd0, oErr}, 32'd1);
    chk("t4_state_idle", {30'd0, oState}, {30'd0, S_IDLE});

    // saturation and zero
    start_load(6'd2);
    @(negedge clk);
    chk("t5_err_cleared", {31'd0, oErr}, 32'd0);
    send_beat(16'h8000);
    send_beat(16'h0000);
    check_done("t5", 6'd2);
    chk("t5_final", {8'd0, oAddrRam_pos, oAddrRam_neg, oWrDtRam}, {8'd0, 4'd1, 4'd1, 16'h0000});

    // reset mid-load cancels the pending beat
    start_load(6'd8);
    send_beat(16'h0011);
    send_beat(16'hFFEE);
    send_beat(16'h0022);
    @(negedge clk);
    iRst = 1'b1; iCoeffValid = 1'b1; iCoeffData = 16'h0055;
    @(posedge clk);
    #1 iRst = 1'b0; iCoeffValid = 1'b0;
    m_pos_cnt = '0; m_neg_cnt = '0; m_pos_addr = '0; m_neg_addr = '0;
    @(negedge clk);
    chk("t6_state_idle", {30'd0, oState}, {30'd0, S_IDLE});
    chk("t6_csn", {31'd0, oCsnRam}, 32'd1);
    chk("t6_wrn", {31'd0, oWrnRam}, 32'd1);
    chk("t6_num", {26'd0, oNumOfCoeff}, 32'd0);
    chk("t6_busy_ready", {30'd0, oBusy, oCoeffReady}, 32'd0);
    chk("t6_addr", {24'd0, oAddrRam_pos, oAddrRam_neg}, 32'd0);
    start_load(6'd2);
    send_beat(16'h0010);
    send_beat(16'hFFF0);
    check_done("t6", 6'd2);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_coeff_loader.md
FIR_COEFF_LOADER -- requirements
Module: fir_coeff_loader

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Port: iClk_12M  input  1  12 MHz system clock; all state changes on its rising edge.
REQ-003 Port: iRst  input  1  synchronous reset, active-high.
REQ-004 Port: iLoadStart  input  1  one-cycle request to start a coefficient load; ignored unless in IDLE.
REQ-005 Port: iNumOfCoeff  input  6  number of coefficients to load; sampled only when the start request is accepted.
REQ-006 Port: iCoeffValid / iCoeffData  input  1 / 16  host coefficient beat; iCoeffData is signed two's complement.
REQ-007 Port: oCoeffReady  output  1  loader accepts the beat this cycle when iCoeffValid=1.
REQ-008 Port: oCoeffiUpdateFlag, oCsnRam, oWrnRam  output  1 each  FIR coefficient-update flag and active-low SRAM strobes.
REQ-009 Port: oAddrRam_pos / oAddrRam_neg  output  4 / 4  positive-bank and negative-bank SRAM addresses.
REQ-010 Port: oWrDtRam  output  16  coefficient magnitude written to SRAM.
REQ-011 Port: oNumOfCoeff  output  6  count of coefficients written in the current or last load.
REQ-012 Port: oBusy / oDone / oErr  output  1 each  load in progress / one-cycle completion pulse / sticky error.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD, DONE and ERR.
REQ-014 In IDLE, a cycle with iLoadStart=1 SHALL latch N=iNumOfCoeff and clear the beat count, both bank counters and oErr.
REQ-015 That cycle SHALL go to ERR if N=0 or N>30, and to LOAD otherwise.
REQ-016 oCoeffReady SHALL be 1 only in LOAD while the beat count is below N; the ready logic is combinational from state and count.
REQ-017 A beat is accepted when iCoeffValid=1 and oCoeffReady=1; accepted beats increment the count.
REQ-018 A beat with iCoeffData>=0 SHALL route to the positive bank; a beat with iCoeffData<0 SHALL route to the negative bank.
REQ-019 Magnitude rule: positive bank writes iCoeffData unchanged; negative bank writes its two's-complement negation.
REQ-020 Magnitude saturation: 0x8000 SHALL be written as 0x7FFF.
REQ-021 Each bank counter starts at 0; the write address is the counter plus 1, so each bank uses addresses 1..15.
REQ-022 Address 0 of each bank is never written by a load.
REQ-023 Write latency: one cycle after acceptance, the block SHALL drive the write for exactly one cycle.
REQ-024 During that write cycle: oCsnRam=0, oWrnRam=0, oWrDtRam=magnitude, and the selected bank's address = its new counter value.
REQ-025 The non-selected bank's address SHALL hold its previous value during a write.
REQ-026 Outside a write cycle, oCsnRam=1 and oWrnRam=1; addresses and oWrDtRam hold their last values.
REQ-027 oNumOfCoeff SHALL equal the number of writes issued so far.
REQ-028 The cycle after the N-th acceptance, the FSM SHALL enter DONE; this cycle also carries the N-th write.
REQ-029 DONE SHALL last one cycle with oDone=1, then return to IDLE.
REQ-030 If a beat would make a bank's counter exceed 15, the FSM SHALL go to ERR and issue no write for that beat.
REQ-031 oCoeffiUpdateFlag SHALL be 1 in LOAD and DONE, and 0 otherwise.
REQ-032 oBusy SHALL be 1 in LOAD, and 0 otherwise.
REQ-033 oErr SHALL be 1 in ERR and SHALL stay set until the next accepted iLoadStart.
REQ-034 ERR SHALL return to IDLE after one cycle; oCoeffReady=0 and no writes occur in ERR.
REQ-035 iLoadStart while in LOAD, DONE or ERR SHALL be ignored.
REQ-036 A stalled host (iCoeffValid=0) SHALL hold the FSM in LOAD indefinitely, with no timeout.

Reset
REQ-037 While iRst=1 at a clock edge, the block SHALL enter IDLE.
REQ-038 Reset outputs: oCsnRam=1, oWrnRam=1, oCoeffiUpdateFlag=0, oCoeffReady=0, oBusy=0, oDone=0, oErr=0.
REQ-039 Reset values: all addresses, oWrDtRam, oNumOfCoeff and all internal counters =0.
REQ-040 Reset asserted mid-LOAD SHALL abort the load; any pending write strobe is cancelled on the same edge.

Verification
REQ-041 Start with N=12; stream 0x0003,-0x0006,0x0007,-0x000B,0x000D,-0x0013,0x0018,-0x0025,0x0030,-0x0066,0x00CE,0x01F4 back-to-back -> pos writes 0x0003,0x0007,0x000D,0x0018,0x0030,0x00CE,0x01F4 at addresses 1..7; neg writes 0x0006,0x000B,0x0013,0x0025,0x0066 at addresses 1..5; oDone pulses one cycle after the 12th accept; oNumOfCoeff=12.
REQ-042 Same N=12 stream with iCoeffValid toggled every other cycle -> identical write contents and order; oCoeffiUpdateFlag stays 1 through LOAD and DONE.
REQ-043 Start with N=0, and separately N=31 -> oErr=1 next cycle, no strobes, oCoeffReady stays 0.
REQ-044 N=20 with 16 positive beats -> addresses 1..15 written; 16th accept causes ERR with no write; oErr sticky until next start.
REQ-045 Beat 0x8000 -> neg bank write of 0x7FFF; beat 0x0000 -> pos bank write of 0x0000.
REQ-046 iRst=1 after 3 of N=8 beats -> IDLE next edge, strobes deasserted, oNumOfCoeff=0; a subsequent start loads normally.
